// File: rtl/hack_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hack_loader_pkg
// Description : Shared constants and state encodings for the Hack ROM UART
//               bootloader (hack_rom_loader / hack_uart_rx). The optional
//               checksum feature is enabled with HACK_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package hack_loader_pkg;

  // Frame start marker
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Width of the running checksum accumulator
  localparam int CKSUM_W = 8;

  // Loader FSM states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN_HI  = 3'd1,
    ST_LEN_LO  = 3'd2,
    ST_DATA_HI = 3'd3,
    ST_DATA_LO = 3'd4,
    ST_CHECK   = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERROR   = 3'd7
  } ld_state_e;

  // UART receiver phases
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/hack_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : hack_uart_rx
// Description : 8N1 UART receiver. Two-flop synchronizer, falling-edge start
//               detect with mid-bit start re-check, LSB-first shift register.
//               Emits one-cycle o_Valid / o_Frame_Err pulses per byte.
// Revision    : 1.0 - initial release
// ============================================================================
module hack_uart_rx
  import hack_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_CLK,
  input  logic       i_RESET_n,
  input  logic       i_RX,
  output logic [7:0] o_Byte,
  output logic       o_Valid,
  output logic       o_Frame_Err
);

  localparam int                CNT_W     = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             meta_q, sync_q, prev_q;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             w_fall;

  // Synchronize the asynchronous serial line and keep one stage of history
  always_ff @(posedge i_CLK) begin
    if (!i_RESET_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= i_RX;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign w_fall = prev_q & ~sync_q;

  // Receiver state and datapath registers
  always_ff @(posedge i_CLK) begin
    if (!i_RESET_n) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Bit timing: start re-checked at half a bit, then one sample per bit
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (w_fall) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          bit_d = '0;
          // A line that is high again at mid-start was only a glitch
          state_d = sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {sync_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
            state_d = RX_STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          valid_d = sync_q;
          ferr_d  = ~sync_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign o_Byte      = shift_q;
  assign o_Valid     = valid_q;
  assign o_Frame_Err = ferr_q;

endmodule
`default_nettype wire

// File: rtl/hack_rom_loader.sv
`default_nettype none
// ============================================================================
// Module      : hack_rom_loader
// Description : UART bootloader for the Hack instruction ROM. Parses
//               A5 / LEN_HI / LEN_LO / words (hi byte first), writes words
//               from address 0 and holds the CPU in reset while loading.
//               Define HACK_LOADER_CHECKSUM_EN to require a trailing 8-bit
//               sum of LEN_HI, LEN_LO and all data bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module hack_rom_loader
  import hack_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int ROM_DEPTH    = 32768
) (
  input  logic        i_CLK,
  input  logic        i_RESET_n,
  input  logic        i_RX,
  output logic [15:0] o_ROM_Address,
  output logic [15:0] o_ROM_Data,
  output logic        o_ROM_Write_EN,
  output logic        o_CPU_RESET_n,
  output logic        o_Busy,
  output logic        o_Error
);

  localparam logic [16:0] DEPTH_LIM = 17'(ROM_DEPTH);

  logic [7:0]  w_rx_byte;
  logic        w_rx_valid;
  logic        w_rx_ferr;
  logic        w_sync_accept;
  logic [15:0] w_len;
  logic        w_len_bad;

  ld_state_e   state_q, state_d;
  logic [7:0]  len_hi_q, len_hi_d;
  logic [7:0]  data_hi_q, data_hi_d;
  logic [15:0] waddr_q, waddr_d;
  logic [15:0] words_q, words_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        we_q, we_d;
  logic        run_q, run_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;

  hack_uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .i_CLK       (i_CLK),
    .i_RESET_n   (i_RESET_n),
    .i_RX        (i_RX),
    .o_Byte      (w_rx_byte),
    .o_Valid     (w_rx_valid),
    .o_Frame_Err (w_rx_ferr)
  );

  // A sync byte restarts a load from either idle or a failed load
  assign w_sync_accept = w_rx_valid && (w_rx_byte == SYNC_BYTE) &&
                         ((state_q == ST_IDLE) || (state_q == ST_ERROR));
  assign w_len         = {len_hi_q, w_rx_byte};
  assign w_len_bad     = (w_len == 16'd0) || ({1'b0, w_len} > DEPTH_LIM);

`ifdef HACK_LOADER_CHECKSUM_EN
  logic [CKSUM_W-1:0] cksum_q, cksum_d;
  logic               w_cksum_ok;

  // Running sum of length and data bytes, restarted by each sync byte
  always_comb begin
    cksum_d = cksum_q;
    if (w_sync_accept) begin
      cksum_d = '0;
    end else if (w_rx_valid && (state_q inside {ST_LEN_HI, ST_LEN_LO,
                                                ST_DATA_HI, ST_DATA_LO})) begin
      cksum_d = cksum_q + w_rx_byte;
    end
  end

  // Checksum accumulator register
  always_ff @(posedge i_CLK) begin
    if (!i_RESET_n) cksum_q <= '0;
    else            cksum_q <= cksum_d;
  end

  assign w_cksum_ok = (w_rx_byte == cksum_q);
`endif

  // Loader state, counters and registered outputs
  always_ff @(posedge i_CLK) begin
    if (!i_RESET_n) begin
      state_q   <= ST_IDLE;
      len_hi_q  <= '0;
      data_hi_q <= '0;
      waddr_q   <= '0;
      words_q   <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      we_q      <= 1'b0;
      run_q     <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_hi_q  <= len_hi_d;
      data_hi_q <= data_hi_d;
      waddr_q   <= waddr_d;
      words_q   <= words_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      we_q      <= we_d;
      run_q     <= run_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  // Frame parser: next state, write issue and status flags
  always_comb begin
    state_d   = state_q;
    len_hi_d  = len_hi_q;
    data_hi_d = data_hi_q;
    waddr_d   = waddr_q;
    words_d   = words_q;
    addr_d    = addr_q;
    data_d    = data_q;
    we_d      = 1'b0;

    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (w_sync_accept) begin
          state_d = ST_LEN_HI;
          waddr_d = '0;
        end
      end
      ST_LEN_HI: begin
        if (w_rx_valid) begin
          len_hi_d = w_rx_byte;
          state_d  = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (w_rx_valid) begin
          words_d = w_len;
          state_d = w_len_bad ? ST_ERROR : ST_DATA_HI;
        end
      end
      ST_DATA_HI: begin
        if (w_rx_valid) begin
          data_hi_d = w_rx_byte;
          state_d   = ST_DATA_LO;
        end
      end
      ST_DATA_LO: begin
        if (w_rx_valid) begin
          // Address/data are held in their own registers so they stay
          // stable after the strobe while the write pointer moves on
          addr_d  = waddr_q;
          data_d  = {data_hi_q, w_rx_byte};
          we_d    = 1'b1;
          waddr_d = waddr_q + 16'd1;
          words_d = words_q - 16'd1;
          if (words_q == 16'd1) begin
`ifdef HACK_LOADER_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            state_d = ST_DONE;
`endif
          end else begin
            state_d = ST_DATA_HI;
          end
        end
      end
`ifdef HACK_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (w_rx_valid) begin
          state_d = w_cksum_ok ? ST_DONE : ST_ERROR;
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A corrupted byte anywhere inside a frame aborts the load
    if (w_rx_ferr && (state_q != ST_IDLE) && (state_q != ST_ERROR)) begin
      state_d = ST_ERROR;
    end

    // CPU runs from idle/done; released the cycle after DONE
    run_d  = w_sync_accept ? 1'b0 : ((state_q == ST_IDLE) || (state_q == ST_DONE));
    busy_d = w_sync_accept |
             (busy_q & (state_q != ST_DONE) & (state_d != ST_ERROR));
    err_d  = (state_d == ST_ERROR);
  end

  assign o_ROM_Address  = addr_q;
  assign o_ROM_Data     = data_q;
  assign o_ROM_Write_EN = we_q;
  assign o_CPU_RESET_n  = run_q;
  assign o_Busy         = busy_q;
  assign o_Error        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_hack_rom_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_hack_rom_loader
// Description : Self-checking bench for hack_rom_loader: table-driven frames,
//               randomized frames against a frame-level reference model, and
//               hand sequences for framing error, mid-load reset and glitch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hack_rom_loader;

  localparam int CPB   = 16;
  localparam int DEPTH = 8;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    int          npre;
    logic [7:0]  pre [2];
    logic [15:0] n;
    int          nsend;
    logic [15:0] w [8];
    bit          exp_err;
    int          exp_nw;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic [15:0] rom_addr, rom_data;
  logic        rom_we, cpu_rst_n, busy, err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bq_t         frm;
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  int          last_we_cyc = 0;
  int          last_rise_cyc = 0;
  int          rx_valid_cnt = 0;
  logic        prev_we = 1'b0;
  logic        prev_run = 1'b0;
  vec_t        vt [7];

  hack_rom_loader #(
    .CLKS_PER_BIT (CPB),
    .ROM_DEPTH    (DEPTH)
  ) dut (
    .i_CLK          (clk),
    .i_RESET_n      (rst_n),
    .i_RX           (rx),
    .o_ROM_Address  (rom_addr),
    .o_ROM_Data     (rom_data),
    .o_ROM_Write_EN (rom_we),
    .o_CPU_RESET_n  (cpu_rst_n),
    .o_Busy         (busy),
    .o_Error        (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Write-port monitor, sampled on the inactive edge
  always @(negedge clk) begin
    if (rom_we) begin
      obs_q.push_back({rom_addr, rom_data});
      last_we_cyc = cyc;
      check("we_single_cycle", {31'd0, prev_we}, 32'd0);
    end
    if (cpu_rst_n && !prev_run) last_rise_cyc = cyc;
    if (dut.u_rx.o_Valid) rx_valid_cnt++;
    prev_we  = rom_we;
    prev_run = cpu_rst_n;
  end

  task automatic send_byte(input logic [7:0] b, input bit good_stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = good_stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic push_word(input logic [15:0] w);
    frm.push_back(w[15:8]);
    frm.push_back(w[7:0]);
  endtask

`ifdef HACK_LOADER_CHECKSUM_EN
  // Append the 8-bit sum of everything after the sync byte
  task automatic push_cksum(input bit corrupt);
    logic [7:0] s;
    int         k;
    s = 8'd0;
    k = 0;
    while (frm[k] != 8'hA5) k++;
    for (int j = k + 1; j < frm.size(); j++) s = s + frm[j];
    frm.push_back(corrupt ? (s ^ 8'h01) : s);
  endtask
`endif

  // Frame-level reference: locate sync, decode length, list expected writes
  function automatic bit model_frame(input bq_t f);
    int s;
    int n;
`ifdef HACK_LOADER_CHECKSUM_EN
    logic [7:0] sum;
`endif
    exp_q.delete();
    s = 0;
    while (s < f.size() && f[s] != 8'hA5) s++;
    n = int'({f[s+1], f[s+2]});
    if (n == 0 || n > DEPTH) return 1'b1;
    for (int k = 0; k < n; k++)
      exp_q.push_back({16'(k), f[s+3+2*k], f[s+4+2*k]});
`ifdef HACK_LOADER_CHECKSUM_EN
    sum = f[s+1] + f[s+2];
    for (int k = 0; k < 2 * n; k++) sum = sum + f[s+3+k];
    return f[s+3+2*n] != sum;
`else
    return 1'b0;
`endif
  endfunction

  // Send the frame in frm and compare against exp_q / exp_err
  task automatic run_frame(input int id, input bit exp_err);
    bit seen_sync;
    int nchk;
    seen_sync = 1'b0;
    obs_q.delete();
    foreach (frm[i]) begin
      send_byte(frm[i], 1'b1);
      if (!seen_sync && frm[i] == 8'hA5) begin
        seen_sync = 1'b1;
        check($sformatf("f%0d_cpu_held_after_sync", id), {31'd0, cpu_rst_n}, 32'd0);
        check($sformatf("f%0d_busy_after_sync", id), {31'd0, busy}, 32'd1);
      end
    end
    repeat (2 * CPB) @(negedge clk);
    check($sformatf("f%0d_nwrites", id), obs_q.size(), exp_q.size());
    nchk = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < nchk; i++)
      check($sformatf("f%0d_write%0d", id, i), obs_q[i], exp_q[i]);
    check($sformatf("f%0d_error", id), {31'd0, err}, {31'd0, exp_err});
    check($sformatf("f%0d_cpu_reset_n", id), {31'd0, cpu_rst_n}, {31'd0, !exp_err});
    check($sformatf("f%0d_busy_end", id), {31'd0, busy}, 32'd0);
    if (!exp_err && exp_q.size() > 0) begin
      check($sformatf("f%0d_hold", id), {rom_addr, rom_data}, exp_q[exp_q.size()-1]);
`ifndef HACK_LOADER_CHECKSUM_EN
      check($sformatf("f%0d_release_timing", id), last_rise_cyc, last_we_cyc + 1);
`endif
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    int         npre;
    logic [7:0] g;
    bit         e;
    int         vcnt;

    // Table of frames and expected outcomes
    vt[0].npre = 0; vt[0].n = 16'd2; vt[0].nsend = 2;
    vt[0].w = '{16'h1234, 16'hABCD, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    vt[0].exp_err = 1'b0; vt[0].exp_nw = 2;
    vt[1].npre = 2; vt[1].pre = '{8'h55, 8'hFF}; vt[1].n = 16'd1; vt[1].nsend = 1;
    vt[1].w = '{16'h0042, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    vt[1].exp_err = 1'b0; vt[1].exp_nw = 1;
    vt[2].npre = 0; vt[2].n = 16'd0; vt[2].nsend = 0;
    vt[2].w = '{default: 16'h0}; vt[2].exp_err = 1'b1; vt[2].exp_nw = 0;
    vt[3].npre = 0; vt[3].n = 16'd3; vt[3].nsend = 3;
    vt[3].w = '{16'hFFFF, 16'h0000, 16'hA5A5, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    vt[3].exp_err = 1'b0; vt[3].exp_nw = 3;
    vt[4].npre = 0; vt[4].n = 16'(DEPTH + 1); vt[4].nsend = 0;
    vt[4].w = '{default: 16'h0}; vt[4].exp_err = 1'b1; vt[4].exp_nw = 0;
    vt[5].npre = 1; vt[5].pre = '{8'h00, 8'h00}; vt[5].n = 16'(DEPTH); vt[5].nsend = DEPTH;
    vt[5].w = '{16'h0101, 16'h2202, 16'h3303, 16'h4404, 16'h5505, 16'h6606, 16'h7707, 16'h8808};
    vt[5].exp_err = 1'b0; vt[5].exp_nw = DEPTH;
    vt[6].npre = 0; vt[6].n = 16'h0100; vt[6].nsend = 0;
    vt[6].w = '{default: 16'h0}; vt[6].exp_err = 1'b1; vt[6].exp_nw = 0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_addr", {16'd0, rom_addr}, 32'd0);
    check("rst_data", {16'd0, rom_data}, 32'd0);
    check("rst_we", {31'd0, rom_we}, 32'd0);
    check("rst_cpu", {31'd0, cpu_rst_n}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_cpu", {31'd0, cpu_rst_n}, 32'd1);
    check("idle_busy", {31'd0, busy}, 32'd0);
    repeat (4) @(negedge clk);

    // Table-driven frames
    for (int i = 0; i < 7; i++) begin
      frm.delete();
      exp_q.delete();
      for (int p = 0; p < vt[i].npre; p++) frm.push_back(vt[i].pre[p]);
      frm.push_back(8'hA5);
      push_word(vt[i].n);
      for (int k = 0; k < vt[i].nsend; k++) push_word(vt[i].w[k]);
`ifdef HACK_LOADER_CHECKSUM_EN
      if (vt[i].nsend > 0) push_cksum(1'b0);
`endif
      for (int k = 0; k < vt[i].exp_nw; k++) exp_q.push_back({16'(k), vt[i].w[k]});
      run_frame(i, vt[i].exp_err);
    end

    // Framing error inside a frame aborts the load
    send_byte(8'hA5, 1'b1);
    check("ferr_busy_after_sync", {31'd0, busy}, 32'd1);
    send_byte(8'h00, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    check("ferr_error", {31'd0, err}, 32'd1);
    check("ferr_cpu_held", {31'd0, cpu_rst_n}, 32'd0);

`ifdef HACK_LOADER_CHECKSUM_EN
    // Wrong checksum: words are written, then the load fails
    frm.delete();
    frm.push_back(8'hA5);
    push_word(16'd2);
    push_word(16'h1234);
    push_word(16'hABCD);
    push_cksum(1'b1);
    e = model_frame(frm);
    run_frame(20, e);
`endif

    // Randomized frames against the reference model
    for (int r = 0; r < 6; r++) begin
      frm.delete();
      npre = $urandom_range(0, 2);
      for (int p = 0; p < npre; p++) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA5) g = 8'h5A;
        frm.push_back(g);
      end
      frm.push_back(8'hA5);
      n = (r == 0) ? DEPTH : $urandom_range(0, DEPTH + 1);
      push_word(16'(n));
      if (n > 0 && n <= DEPTH) begin
        for (int k = 0; k < n; k++) push_word(16'($urandom_range(0, 65535)));
`ifdef HACK_LOADER_CHECKSUM_EN
        push_cksum($urandom_range(0, 3) == 0);
`endif
      end
      e = model_frame(frm);
      run_frame(100 + r, e);
    end

    // Reset after the first data word of a load
    frm.delete();
    obs_q.delete();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    check("midrst_one_write", obs_q.size(), 32'd1);
    if (obs_q.size() > 0) check("midrst_write0", obs_q[0], 32'h0000_1234);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_addr", {16'd0, rom_addr}, 32'd0);
    check("midrst_data", {16'd0, rom_data}, 32'd0);
    check("midrst_cpu", {31'd0, cpu_rst_n}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_idle_cpu", {31'd0, cpu_rst_n}, 32'd1);
    check("midrst_idle_busy", {31'd0, busy}, 32'd0);

    // Short glitch in idle must not produce a byte
    vcnt = rx_valid_cnt;
    rx = 1'b0;
    repeat ((CPB * 3) / 10) @(negedge clk);
    rx = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    check("glitch_no_byte", rx_valid_cnt, vcnt);
    check("glitch_busy", {31'd0, busy}, 32'd0);

    // Normal load after the reset and glitch
    frm.delete();
    frm.push_back(8'hA5);
    push_word(16'd2);
    push_word(16'h1234);
    push_word(16'hABCD);
`ifdef HACK_LOADER_CHECKSUM_EN
    push_cksum(1'b0);
`endif
    e = model_frame(frm);
    run_frame(200, e);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
